// File: rtl/l2_cache_pkg.sv
// Shared types and encodings for the L2 cache controller slice.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    REFILL    = 3'd4
  } state_t;

  // data_array{0,1}_mux encodings
  localparam logic [1:0] DA_NONE = 2'b00;
  localparam logic [1:0] DA_BYTE = 2'b01;
  localparam logic [1:0] DA_LINE = 2'b10;

  // datain{0,1}_mux encodings
  localparam logic DIN_CPU  = 1'b0;
  localparam logic DIN_PMEM = 1'b1;

endpackage

// File: rtl/l2_cache_control_if.sv
// Request/response handshakes around the L2 controller.
// Upstream: mem_read/mem_write are held by the requester until the one-cycle
// mem_resp pulse; mem_write wins when both are high. Downstream: pmem_read or
// pmem_write is held by the controller until the one-cycle pmem_resp pulse.
// The slave modport is the controller's view (it answers upstream and drives
// physical memory); the master modport is the surrounding system's view.
interface l2_cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport slave (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );

  modport master (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module l2_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc until the maximum value is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// Sequencing FSM for a 2-way write-back/write-allocate L2 cache datapath.
// Array reads are synchronous, so the tag compare happens one cycle after the
// request is seen. A miss refills the victim (lru) way, writing it back first
// if dirty, then retries the compare; the retry is not counted a second time.
module l2_cache_control
  import l2_cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  l2_cache_control_if.slave bus,
  input  logic             hit_way0,
  input  logic             hit_way1,
  input  logic             lru,
  input  logic             dirty0,
  input  logic             dirty1,
  output logic             load_mem_address_reg,
  output logic             load_pmem_reg,
  output logic             load_way0_tag,
  output logic             load_way1_tag,
  output logic             load_way0_valid,
  output logic             load_way1_valid,
  output logic             load_way0_dirty,
  output logic             load_way1_dirty,
  output logic             load_lru,
  output logic             valid_mux,
  output logic             dirty_mux,
  output logic             lru_mux,
  output logic [1:0]       data_array0_mux,
  output logic [1:0]       data_array1_mux,
  output logic             datain0_mux,
  output logic             datain1_mux,
  output logic             pmem_control,
  output logic             read_way0,
  output logic             read_way1,
  output logic             read_lru,
  output logic             read_way0_data,
  output logic             read_way1_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_COMPARE   = COMPARE;
  localparam logic [2:0] ST_WRITEBACK = WRITEBACK;
  localparam logic [2:0] ST_ALLOCATE  = ALLOCATE;
  localparam logic [2:0] ST_REFILL    = REFILL;

  logic [2:0] state, state_next;
  logic       retry;      // current compare follows a refill of this request
  logic       req, hit, way;
  logic       hit_inc, miss_inc;

  assign req = bus.mem_read | bus.mem_write;
  assign hit = hit_way0 | hit_way1;
  assign way = hit_way1;

  // The datapath latches nothing on address and always reads its arrays.
  assign load_mem_address_reg = 1'b0;
  assign load_pmem_reg        = 1'b0;
  assign read_way0            = 1'b1;
  assign read_way1            = 1'b1;
  assign read_lru             = 1'b1;
  assign read_way0_data       = 1'b1;
  assign read_way1_data       = 1'b1;
  assign state_dbg            = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Remember that a miss of the current request has already been counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     retry <= 1'b0;
    else if (state == ST_COMPARE) retry <= ~hit;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next      = state;
    bus.mem_resp    = 1'b0;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    load_way0_tag   = 1'b0;
    load_way1_tag   = 1'b0;
    load_way0_valid = 1'b0;
    load_way1_valid = 1'b0;
    load_way0_dirty = 1'b0;
    load_way1_dirty = 1'b0;
    load_lru        = 1'b0;
    valid_mux       = 1'b0;
    dirty_mux       = 1'b0;
    lru_mux         = 1'b0;
    data_array0_mux = DA_NONE;
    data_array1_mux = DA_NONE;
    datain0_mux     = DIN_CPU;
    datain1_mux     = DIN_CPU;
    pmem_control    = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) state_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (hit) begin
          bus.mem_resp = 1'b1;
          load_lru     = 1'b1;
          lru_mux      = ~way;
          hit_inc      = ~retry;
          if (bus.mem_write) begin
            dirty_mux = 1'b1;
            if (way) begin
              load_way1_dirty = 1'b1;
              data_array1_mux = DA_BYTE;
            end else begin
              load_way0_dirty = 1'b1;
              data_array0_mux = DA_BYTE;
            end
          end
          state_next = ST_IDLE;
        end else begin
          miss_inc   = ~retry;
          state_next = (lru ? dirty1 : dirty0) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        pmem_control   = 1'b1;
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          if (lru) load_way1_dirty = 1'b1;
          else     load_way0_dirty = 1'b1;
          state_next = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          valid_mux = 1'b1;
          if (lru) begin
            data_array1_mux = DA_LINE;
            datain1_mux     = DIN_PMEM;
            load_way1_tag   = 1'b1;
            load_way1_valid = 1'b1;
            load_way1_dirty = 1'b1;
          end else begin
            data_array0_mux = DA_LINE;
            datain0_mux     = DIN_PMEM;
            load_way0_tag   = 1'b1;
            load_way0_valid = 1'b1;
            load_way0_dirty = 1'b1;
          end
          state_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        state_next = ST_COMPARE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The requester must hold its request until it is answered.
  req_held_a: assert property (@(posedge clk) disable iff (!rst)
    (state != ST_IDLE) |-> req);

  l2_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc(hit_inc), .count(hit_count)
  );

  l2_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(miss_inc), .count(miss_count)
  );

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: a one-set datapath stand-in, a 3-cycle pmem
// model and a scoreboard of expected response events.
module tb_l2_cache_control;
  import l2_cache_pkg::*;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [7:0] lat;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_control;
    logic [1:0] ld_tag;
    logic [1:0] ld_valid;
    logic [1:0] ld_dirty;
    logic       load_lru;
    logic       valid_mux;
    logic       dirty_mux;
    logic       lru_mux;
    logic [1:0] da0;
    logic [1:0] da1;
    logic       din0;
    logic       din1;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  l2_cache_control_if bus ();
  logic hit_way0, hit_way1, lru, dirty0, dirty1;
  logic load_mem_address_reg, load_pmem_reg;
  logic load_way0_tag, load_way1_tag, load_way0_valid, load_way1_valid;
  logic load_way0_dirty, load_way1_dirty, load_lru;
  logic valid_mux, dirty_mux, lru_mux;
  logic [1:0] data_array0_mux, data_array1_mux;
  logic datain0_mux, datain1_mux, pmem_control;
  logic read_way0, read_way1, read_lru, read_way0_data, read_way1_data;
  logic [CNT_W-1:0] hit_count, miss_count;
  logic [2:0] state_dbg;

  l2_cache_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit_way0(hit_way0), .hit_way1(hit_way1), .lru(lru),
    .dirty0(dirty0), .dirty1(dirty1),
    .load_mem_address_reg(load_mem_address_reg), .load_pmem_reg(load_pmem_reg),
    .load_way0_tag(load_way0_tag), .load_way1_tag(load_way1_tag),
    .load_way0_valid(load_way0_valid), .load_way1_valid(load_way1_valid),
    .load_way0_dirty(load_way0_dirty), .load_way1_dirty(load_way1_dirty),
    .load_lru(load_lru), .valid_mux(valid_mux), .dirty_mux(dirty_mux),
    .lru_mux(lru_mux), .data_array0_mux(data_array0_mux),
    .data_array1_mux(data_array1_mux), .datain0_mux(datain0_mux),
    .datain1_mux(datain1_mux), .pmem_control(pmem_control),
    .read_way0(read_way0), .read_way1(read_way1), .read_lru(read_lru),
    .read_way0_data(read_way0_data), .read_way1_data(read_way1_data),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // ---------------- pmem model: answers on the 3rd cycle of a request -----
  logic pm_resp = 1'b0;
  logic stray_resp = 1'b0;
  int   pm_cnt = 0;
  assign bus.pmem_resp = pm_resp | stray_resp;

  always @(posedge clk) begin
    #1;
    if (rst && (bus.pmem_read || bus.pmem_write)) begin
      if (pm_cnt == 2) begin
        pm_resp = 1'b1;
        pm_cnt  = 0;
      end else begin
        pm_resp = 1'b0;
        pm_cnt++;
      end
    end else begin
      pm_resp = 1'b0;
      pm_cnt  = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [27:0] exp_q[$];
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] e_hit(input int lat, input bit w, input bit wr);
    ev_t e = '0;
    e.lat = 8'(lat); e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_mux = ~w;
    if (wr) begin
      e.dirty_mux = 1'b1;
      e.ld_dirty[w] = 1'b1;
      if (w) e.da1 = DA_BYTE; else e.da0 = DA_BYTE;
    end
    return e;
  endfunction

  function automatic logic [27:0] e_alloc(input int lat, input bit v);
    ev_t e = '0;
    e.lat = 8'(lat); e.pmem_read = 1'b1; e.valid_mux = 1'b1;
    e.ld_tag[v] = 1'b1; e.ld_valid[v] = 1'b1; e.ld_dirty[v] = 1'b1;
    if (v) begin e.da1 = DA_LINE; e.din1 = DIN_PMEM; end
    else   begin e.da0 = DA_LINE; e.din0 = DIN_PMEM; end
    return e;
  endfunction

  function automatic logic [27:0] e_wb(input int lat, input bit v);
    ev_t e = '0;
    e.lat = 8'(lat); e.pmem_write = 1'b1; e.pmem_control = 1'b1;
    e.ld_dirty[v] = 1'b1;
    return e;
  endfunction

  // Monitor: compare every response event, then update the set model.
  always @(negedge clk) begin
    ev_t a;
    logic [27:0] e;
    if (rst) begin
      if (bus.mem_resp || ((bus.pmem_read || bus.pmem_write) && bus.pmem_resp)) begin
        a = '0;
        a.lat = 8'(cyc - start_cyc + 1);
        a.mem_resp = bus.mem_resp; a.pmem_read = bus.pmem_read;
        a.pmem_write = bus.pmem_write; a.pmem_control = pmem_control;
        a.ld_tag = {load_way1_tag, load_way0_tag};
        a.ld_valid = {load_way1_valid, load_way0_valid};
        a.ld_dirty = {load_way1_dirty, load_way0_dirty};
        a.load_lru = load_lru; a.valid_mux = valid_mux;
        a.dirty_mux = dirty_mux; a.lru_mux = lru_mux;
        a.da0 = data_array0_mux; a.da1 = data_array1_mux;
        a.din0 = datain0_mux; a.din1 = datain1_mux;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event got=%h exp=none (t=%0t)", a, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_event", 32'(a), 32'(e));
        end
      end
      if (load_way0_tag) begin hit_way0 = 1'b1; hit_way1 = 1'b0; end
      if (load_way1_tag) begin hit_way1 = 1'b1; hit_way0 = 1'b0; end
      if (load_lru) lru = lru_mux;
      if (load_way0_dirty) dirty0 = dirty_mux;
      if (load_way1_dirty) dirty1 = dirty_mux;
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit wr, input bit h0, input bit h1, input bit l,
                        input bit d0, input bit d1);
    int n;
    @(posedge clk); #1;
    hit_way0 = h0; hit_way1 = h1; lru = l; dirty0 = d0; dirty1 = d1;
    bus.mem_write = wr; bus.mem_read = ~wr;
    start_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_resp && n < 40);
    if (!bus.mem_resp) begin
      checks++; failures++;
      $display("FAIL req_timeout got=no_resp exp=mem_resp (t=%0t)", $time);
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    hit_way0 = 1'b0; hit_way1 = 1'b0; lru = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0;

    // Reset state
    #2;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_resp", {29'd0, bus.mem_resp, bus.pmem_read, bus.pmem_write}, 32'd0);
    check("rst_hit_cnt", 32'(hit_count), 32'd0);
    check("rst_miss_cnt", 32'(miss_count), 32'd0);
    check("rst_read_tied", {27'd0, read_way0, read_way1, read_lru, read_way0_data, read_way1_data}, 32'h1f);
    check("rst_loads", {29'd0, load_lru, load_mem_address_reg, load_pmem_reg}, 32'd0);
    #10 rst = 1'b1;

    // 1: cold read 0x40, clean miss into way0
    exp_q.push_back(e_alloc(5, 1'b0));
    exp_q.push_back(e_hit(7, 1'b0, 1'b0));
    do_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1_miss_cnt", 32'(miss_count), 32'd1);
    check("s1_hit_cnt", 32'(hit_count), 32'd0);

    // 2: read 0x40 again, hit way0 in 2 cycles
    exp_q.push_back(e_hit(2, 1'b0, 1'b0));
    do_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s2_hit_cnt", 32'(hit_count), 32'd1);
    check("s2_lru", 32'(lru), 32'd1);

    // 3: write 0x40, byte-enable write into way0, marks dirty
    exp_q.push_back(e_hit(2, 1'b0, 1'b1));
    do_req(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s3_hit_cnt", 32'(hit_count), 32'd2);
    check("s3_dirty0", 32'(dirty0), 32'd1);

    // 4a: read 0x140, clean miss fills way1
    exp_q.push_back(e_alloc(5, 1'b1));
    exp_q.push_back(e_hit(7, 1'b1, 1'b0));
    do_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("s4a_miss_cnt", 32'(miss_count), 32'd2);

    // 4b: read 0x240, victim way0 is dirty: writeback then allocate
    exp_q.push_back(e_wb(5, 1'b0));
    exp_q.push_back(e_alloc(8, 1'b0));
    exp_q.push_back(e_hit(10, 1'b0, 1'b0));
    do_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s4b_miss_cnt", 32'(miss_count), 32'd3);
    check("s4b_hit_cnt", 32'(hit_count), 32'd2);
    check("s4b_dirty0", 32'(dirty0), 32'd0);

    // Stray pmem_resp while idle has no effect
    @(posedge clk); #1 stray_resp = 1'b1;
    @(posedge clk); #1 stray_resp = 1'b0;
    @(posedge clk); #1;
    check("stray_state", 32'(state_dbg), 32'(IDLE));
    check("stray_counts", {24'd0, hit_count, miss_count}, 32'h23);

    // 5: reset while in ALLOCATE; the request is never answered
    @(posedge clk); #1;
    hit_way0 = 1'b0; hit_way1 = 1'b0; lru = 1'b1; dirty0 = 1'b0; dirty1 = 1'b0;
    bus.mem_read = 1'b1;
    start_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state_dbg != 3'(ALLOCATE) && n < 20);
    check("s5_reach_alloc", 32'(state_dbg), 32'(ALLOCATE));
    @(posedge clk); #3;
    check("s5_pmem_read_before", 32'(bus.pmem_read), 32'd1);
    rst = 1'b0;
    #1;
    check("s5_pmem_read_drop", 32'(bus.pmem_read), 32'd0);
    check("s5_state", 32'(state_dbg), 32'(IDLE));
    check("s5_counts", {24'd0, hit_count, miss_count}, 32'd0);
    bus.mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("s5_idle_after", 32'(state_dbg), 32'(IDLE));

    // 6: hit counter saturates at 15
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(e_hit(2, 1'b0, 1'b0));
      do_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 14) check("s6_hit_15", 32'(hit_count), 32'd15);
    end
    check("s6_hit_sat", 32'(hit_count), 32'd15);
    check("s6_miss", 32'(miss_count), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
